// File: rtl/miss_delay_timer.sv
// Stop-window timer for IC read misses: a sampled `delay` holds `stop` high for
// LATENCY unstalled cycles. Optional per-cycle trace under DELAYER_PRINT_EN.
module miss_delay_timer #(
  parameter int LATENCY = 9,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic delay,
  output logic stop
);

  if (LATENCY < 0 || LATENCY > (2**CNT_W) - 1) begin : g_bad_latency
    $error("miss_delay_timer: LATENCY=%0d does not fit CNT_W=%0d", LATENCY, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stall outranks everything, so `delay` is never looked at while frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall) begin
      if (cnt_q != '0)
        cnt_d = cnt_q - ONE_C;
      else if (delay)
        cnt_d = LAT_C;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stop = (cnt_q != '0);

`ifdef DELAYER_PRINT_EN
  always @(posedge clk) begin
    if (reset)
      $display("%m: delay=%b stall=%b cnt=%0d stop=%b", delay, stall, cnt_q, stop);
  end
`endif

endmodule

// File: tb/tb_miss_delay_timer.sv
// Scoreboard bench for miss_delay_timer: expected `stop` pushed per driven cycle,
// popped and compared one time unit after the following rising edge.
module tb_miss_delay_timer;
  localparam int LATENCY = 9;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  logic delay = 1'b1;
  logic stop;

  miss_delay_timer #(.LATENCY(LATENCY), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .delay (delay),
    .stop  (stop)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   mcnt  = 0;
  int   highs = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, predict the post-edge stop, then check it after the edge.
  task automatic step(input logic d, input logic s, input string tag);
    logic obs;
    @(negedge clk);
    delay = d;
    stall = s;
    if (!reset)        mcnt = 0;
    else if (s !== 1'b1) begin
      if (mcnt != 0)   mcnt = mcnt - 1;
      else if (d === 1'b1) mcnt = LATENCY;
    end
    exp_q.push_back(mcnt != 0);
    @(posedge clk);
    #1;
    obs = stop;
    if (obs === 1'b1) highs++;
    chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    delay = 1'b0;
    stall = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset held with delay high
    #1 chk("rst_state", stop, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "rst_hold");
    release_reset();
    idle(3, "rst_release");

    // Single trigger: exactly LATENCY high cycles
    highs = 0;
    step(1'b1, 1'b0, "single_trig");
    idle(12, "single_run");
    chk_int("single_len", highs, 9);

    // Stall freeze with delay asserted during the stall
    highs = 0;
    step(1'b1, 1'b0, "stall_trig");
    idle(3, "stall_pre");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "stall_hold");
    idle(10, "stall_post");
    chk_int("stall_len", highs, 12);

    // Stalled trigger, including X on delay while stalled
    step(1'b1, 1'b1, "stalled_trig0");
    step(1'bx, 1'b1, "stalled_trigx");
    step(1'b1, 1'b1, "stalled_trig1");
    highs = 0;
    step(1'b1, 1'b0, "unstall_trig");
    idle(10, "unstall_run");
    chk_int("unstall_len", highs, 9);

    // Mid-window delay pulse does not extend
    highs = 0;
    step(1'b1, 1'b0, "pulse_trig");
    idle(3, "pulse_pre");
    step(1'b1, 1'b0, "pulse_mid");
    idle(8, "pulse_post");
    chk_int("pulse_len", highs, 9);

    // Continuous delay: 9 high / 1 low
    highs = 0;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, "cont");
    chk_int("cont_highs", highs, 23);
    idle(11, "cont_drain");

    // Async reset on the 5th stop cycle, between edges
    step(1'b1, 1'b0, "arst_trig");
    idle(4, "arst_pre");
    chk("arst_before", stop, 1'b1);
    #2 reset = 1'b0;
    #1 chk("arst_now", stop, 1'b0);
    mcnt = 0;
    step(1'b0, 1'b0, "arst_held");
    release_reset();
    idle(4, "arst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
